// File: rtl/clock_disp_pkg.sv
// Shared constants for the multiplexed clock display: segment codes,
// digit count and the legal upper limit of each time field.
package clock_disp_pkg;

    localparam int NUM_DIGITS = 6;

    // Largest legal binary value of each field
    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] HOUR_MAX = 6'd23;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/clock_display_scan_seg7_decoder.sv
// BCD digit to active-low 7-segment pattern; dash overrides the digit.
// Ports: bcd (4-bit digit), dash (show '-'), seg ({g..a}, active-low).
module seg7_decoder
    import clock_disp_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/clock_display_scan.sv
// Scans a snapshotted hh:mm:ss onto a 6-digit common-anode 7-seg display.
// Ports: clk_100/rst (sync, active-high), second/minute/hour (binary in),
// an (digit enables, low), seg/dp (segments, low), frame_tick (load pulse).
module clock_display_scan
    import clock_disp_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000
) (
    input  logic       clk_100,
    input  logic       rst,
    input  logic [5:0] second,
    input  logic [5:0] minute,
    input  logic [5:0] hour,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int DW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIGIT_CYCLES - 1);
    localparam logic [2:0] IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [DW-1:0] div;
    logic [2:0]    idx;
    logic [5:0]    snap_sec;
    logic [5:0]    snap_min;
    logic [5:0]    snap_hour;
    logic          load_pending;

    logic          term;
    logic          load;
    logic [5:0]    field;
    logic          field_bad;
    logic [7:0]    bcd;
    logic [3:0]    digit;
    logic [6:0]    seg_next;

    // Binary 0..63 to {tens, units} by a compare chain
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'd0;
        u = v[3:0];
        if (v >= 6'd60) begin
            t = 4'd6;
            u = 4'(v - 6'd60);
        end else if (v >= 6'd50) begin
            t = 4'd5;
            u = 4'(v - 6'd50);
        end else if (v >= 6'd40) begin
            t = 4'd4;
            u = 4'(v - 6'd40);
        end else if (v >= 6'd30) begin
            t = 4'd3;
            u = 4'(v - 6'd30);
        end else if (v >= 6'd20) begin
            t = 4'd2;
            u = 4'(v - 6'd20);
        end else if (v >= 6'd10) begin
            t = 4'd1;
            u = 4'(v - 6'd10);
        end
        return {t, u};
    endfunction

    assign term = (div == DIV_LAST);
    // A new frame's snapshot is taken as the last digit finishes,
    // so every digit of a frame comes from the same sample.
    assign load = load_pending || (term && (idx == IDX_LAST));

    always_comb begin
        field     = snap_sec;
        field_bad = (snap_sec > SEC_MAX);
        case (idx)
            3'd2, 3'd3: begin
                field     = snap_min;
                field_bad = (snap_min > MIN_MAX);
            end
            3'd4, 3'd5: begin
                field     = snap_hour;
                field_bad = (snap_hour > HOUR_MAX);
            end
            default: ;
        endcase
    end

    assign bcd   = to_bcd(field);
    // Odd positions are the tens digit of their field
    assign digit = idx[0] ? bcd[7:4] : bcd[3:0];

    seg7_decoder u_dec (
        .bcd  (digit),
        .dash (field_bad),
        .seg  (seg_next)
    );

    always_ff @(posedge clk_100) begin
        if (rst) begin
            div          <= '0;
            idx          <= '0;
            snap_sec     <= '0;
            snap_min     <= '0;
            snap_hour    <= '0;
            load_pending <= 1'b1;
            an           <= 6'b111111;
            seg          <= SEG_BLANK;
            dp           <= 1'b1;
            frame_tick   <= 1'b0;
        end else begin
            frame_tick <= load;
            if (load) begin
                snap_sec     <= second;
                snap_min     <= minute;
                snap_hour    <= hour;
                load_pending <= 1'b0;
            end
            // The scan is held off until the first snapshot exists,
            // which keeps the display dark for that one cycle and
            // gives the first digit its full hold time.
            if (load_pending) begin
                an  <= 6'b111111;
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end else begin
                div <= term ? '0 : div + 1'b1;
                if (term) begin
                    idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
                end
                an  <= ~(6'd1 << idx);
                seg <= seg_next;
                dp  <= ~((idx == 3'd2) || (idx == 3'd4));
            end
        end
    end

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan with DIGIT_CYCLES=4.
// Walks whole frames and compares every cycle against hand-coded digits.
module tb_clock_display_scan;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;

    logic       clk_100 = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] second = 6'd0;
    logic [5:0] minute = 6'd0;
    logic [5:0] hour = 6'd0;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    clock_display_scan #(.DIGIT_CYCLES(4)) dut (
        .clk_100    (clk_100),
        .rst        (rst),
        .second     (second),
        .minute     (minute),
        .hour       (hour),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk_100 = ~clk_100;

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] got,
                       input logic [6:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_blank(input string tag, input logic ft);
        chk({tag, " an"}, {1'b0, an}, 7'b0111111);
        chk({tag, " seg"}, seg, SB);
        chk({tag, " dp"}, {6'd0, dp}, 7'd1);
        chk({tag, " ft"}, {6'd0, frame_tick}, {6'd0, ft});
    endtask

    // Starts on the first cycle of a frame's idx0 and ends on the
    // first cycle of the following frame. e[d] is digit d's segments.
    task automatic check_frame(input string tag,
                               input logic [5:0][6:0] e);
        logic [5:0] ea;
        logic       edp;
        logic       eft;
        for (int d = 0; d < 6; d++) begin
            for (int c = 0; c < 4; c++) begin
                ea  = ~(6'd1 << d);
                edp = !(d == 2 || d == 4);
                eft = (d == 5 && c == 3);
                chk($sformatf("%s d%0d c%0d an", tag, d, c),
                    {1'b0, an}, {1'b0, ea});
                chk($sformatf("%s d%0d c%0d seg", tag, d, c),
                    seg, e[d]);
                chk($sformatf("%s d%0d c%0d dp", tag, d, c),
                    {6'd0, dp}, {6'd0, edp});
                chk($sformatf("%s d%0d c%0d ft", tag, d, c),
                    {6'd0, frame_tick}, {6'd0, eft});
                tick();
            end
        end
    endtask

    initial begin
        hour   = 6'd12;
        minute = 6'd34;
        second = 6'd56;
        tick();
        tick();
        chk_blank("reset", 1'b0);

        rst = 1'b0;
        tick();
        chk_blank("first load", 1'b1);
        tick();
        chk("cycle2 an", {1'b0, an}, 7'b0111110);
        chk("cycle2 seg", seg, S6);

        // Change lands mid-frame: must wait for the next snapshot
        second = 6'd57;
        check_frame("12:34:56", {S1, S2, S3, S4, S5, S6});

        hour   = 6'd23;
        minute = 6'd59;
        second = 6'd59;
        check_frame("12:34:57", {S1, S2, S3, S4, S5, S7});

        hour   = 6'd0;
        minute = 6'd0;
        second = 6'd0;
        check_frame("23:59:59", {S2, S3, S5, S9, S5, S9});

        hour   = 6'd24;
        minute = 6'd60;
        second = 6'd63;
        check_frame("00:00:00", {S0, S0, S0, S0, S0, S0});

        hour = 6'd23;
        check_frame("all bad", {SD, SD, SD, SD, SD, SD});

        hour   = 6'd12;
        minute = 6'd34;
        second = 6'd56;
        // Snapshot for this frame was taken before the line above
        for (int i = 0; i < 12; i++) begin
            tick();
        end
        chk("pre-reset idx3 an", {1'b0, an}, 7'b0110111);
        chk("pre-reset idx3 seg", seg, SD);

        rst = 1'b1;
        tick();
        chk_blank("mid reset", 1'b0);
        rst = 1'b0;
        tick();
        chk_blank("reload", 1'b1);
        tick();
        check_frame("after reset", {S1, S2, S3, S4, S5, S6});

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
